// File: rtl/tx_pattern_pkg.sv
// Shared types and constants for the multi-lane TX test-pattern source.
// Holds the sequencer state encoding, payload modes, PRBS7 polynomial and training-word helper.
package tx_pattern_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_PHY = 3'd1,
        ST_TRAIN    = 3'd2,
        ST_SYNC     = 3'd3,
        ST_RUN      = 3'd4
    } state_t;

    localparam logic [1:0] MODE_COUNTER = 2'd0;
    localparam logic [1:0] MODE_PRBS7   = 2'd1;
    localparam logic [1:0] MODE_FIXED   = 2'd2;
    localparam logic [1:0] MODE_RSVD    = 2'd3;

    // x^7 + x^6 + 1: feedback is the XOR of the two oldest history bits
    localparam int         PRBS_TAP_HI = 6;
    localparam int         PRBS_TAP_LO = 5;
    localparam logic [6:0] PRBS_SEED   = 7'h7F;

    function automatic logic [15:0] train_word(input int width);
        logic [15:0] w;
        logic        bit_v;
        w     = 16'h0000;
        bit_v = 1'b1;
        for (int j = 15; j >= 0; j--) begin
            if (j < width) begin
                w[j]  = bit_v;
                bit_v = ~bit_v;
            end else begin
                w[j] = 1'b0;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/tx_pattern_gen_if.sv
// Control/data bundle between the test controller and the pattern source.
// The controller side is the master; the pattern source is the slave.
interface tx_pattern_gen_if #(
    parameter int DATA_W = 8,
    parameter int LANES  = 1
);
    logic                      start;
    logic                      stop;
    logic [1:0]                mode;
    logic [DATA_W-1:0]         fixed_word;
    logic                      phy_ready;
    logic [LANES*DATA_W-1:0]   data_out;
    logic                      data_valid;
    logic                      sync_flag;
    logic                      busy;
    logic [31:0]               word_count;

    modport master (
        output start, stop, mode, fixed_word, phy_ready,
        input  data_out, data_valid, sync_flag, busy, word_count
    );

    modport slave (
        input  start, stop, mode, fixed_word, phy_ready,
        output data_out, data_valid, sync_flag, busy, word_count
    );
endinterface

// File: rtl/prbs7_lane.sv
// One PRBS7 lane: Fibonacci LFSR stepped DATA_W bits per advance, first generated bit in the MSB.
// The output word is the batch that the next advance will consume.
module prbs7_lane
    import tx_pattern_pkg::*;
#(
    parameter int         DATA_W = 8,
    parameter logic [6:0] SEED   = PRBS_SEED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reseed,
    input  logic              advance,
    output logic [DATA_W-1:0] word
);

    logic [6:0]        lfsr_r;
    logic [6:0]        lfsr_next_s;
    logic [DATA_W-1:0] word_s;

    // Unroll DATA_W LFSR steps, collecting each new bit MSB-first
    always_comb begin
        lfsr_next_s = lfsr_r;
        word_s      = '0;
        for (int k = 0; k < DATA_W; k++) begin
            word_s[DATA_W-1-k] = lfsr_next_s[PRBS_TAP_HI] ^ lfsr_next_s[PRBS_TAP_LO];
            lfsr_next_s        = {lfsr_next_s[5:0], word_s[DATA_W-1-k]};
        end
    end

    // LFSR state register with reseed priority over advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_r <= SEED;
        end else if (reseed) begin
            lfsr_r <= SEED;
        end else if (advance) begin
            lfsr_r <= lfsr_next_s;
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    assign word = word_s;

endmodule

// File: rtl/tx_pattern_gen.sv
// Multi-lane TX test-pattern source: PHY wait, training, sync word, then counter/PRBS7/fixed payload.
// Lane outputs are registered from the current state, so they trail the state register by one cycle.
module tx_pattern_gen
    import tx_pattern_pkg::*;
#(
    parameter int          DATA_W    = 8,
    parameter int          LANES     = 1,
    parameter int          TRAIN_LEN = 64,
    parameter logic [31:0] SYNC_WORD = 32'h0000_00BC
) (
    input  logic           clk,
    input  logic           rst_n,
    tx_pattern_gen_if.slave bus
);

    localparam int                TC_W       = (TRAIN_LEN > 1) ? $clog2(TRAIN_LEN) : 1;
    localparam logic [TC_W-1:0]   TRAIN_LAST = TC_W'(TRAIN_LEN - 1);
    localparam logic [15:0]       TRAIN_W16  = train_word(DATA_W);
    localparam logic [DATA_W-1:0] TRAIN_LANE = TRAIN_W16[DATA_W-1:0];
    localparam logic [DATA_W-1:0] SYNC_LANE  = SYNC_WORD[DATA_W-1:0];
    localparam logic [DATA_W-1:0] CNT_ONE    = {{(DATA_W-1){1'b0}}, 1'b1};

    state_t                  state_r;
    logic [1:0]              mode_r;
    logic [DATA_W-1:0]       fixed_r;
    logic [DATA_W-1:0]       cnt_r;
    logic [TC_W-1:0]         train_cnt_r;
    logic [DATA_W-1:0]       prbs_word_s [LANES];
    logic [LANES*DATA_W-1:0] payload_s;
    logic                    reseed_s;
    logic                    advance_s;

    // Generators only run in RUN; every other state holds them at their seeds
    assign reseed_s  = (state_r != ST_RUN);
    assign advance_s = (state_r == ST_RUN);
    assign bus.busy  = (state_r != ST_IDLE);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        prbs7_lane #(
            .DATA_W (DATA_W),
            .SEED   (PRBS_SEED ^ 7'(i))
        ) u_prbs (
            .clk     (clk),
            .rst_n   (rst_n),
            .reseed  (reseed_s),
            .advance (advance_s),
            .word    (prbs_word_s[i])
        );
    end

    // Per-lane payload selection for the latched mode
    always_comb begin
        payload_s = '0;
        for (int i = 0; i < LANES; i++) begin
            case (mode_r)
                MODE_COUNTER: payload_s[i*DATA_W +: DATA_W] = cnt_r + DATA_W'(i);
                MODE_PRBS7:   payload_s[i*DATA_W +: DATA_W] = prbs_word_s[i];
                default:      payload_s[i*DATA_W +: DATA_W] = fixed_r;
            endcase
        end
    end

    // Sequencer state, latched configuration and registered lane outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            mode_r         <= MODE_COUNTER;
            fixed_r        <= '0;
            cnt_r          <= '0;
            train_cnt_r    <= '0;
            bus.data_out   <= '0;
            bus.data_valid <= 1'b0;
            bus.sync_flag  <= 1'b0;
            bus.word_count <= 32'd0;
        end else begin
            case (state_r)
                ST_TRAIN: begin
                    bus.data_out   <= {LANES{TRAIN_LANE}};
                    bus.data_valid <= 1'b0;
                    bus.sync_flag  <= 1'b0;
                end
                ST_SYNC: begin
                    bus.data_out   <= {LANES{SYNC_LANE}};
                    bus.data_valid <= 1'b0;
                    bus.sync_flag  <= 1'b1;
                end
                ST_RUN: begin
                    bus.data_out   <= payload_s;
                    bus.data_valid <= 1'b1;
                    bus.sync_flag  <= 1'b0;
                    if (bus.word_count != 32'hFFFF_FFFF) begin
                        bus.word_count <= bus.word_count + 32'd1;
                    end else begin
                        bus.word_count <= bus.word_count;
                    end
                end
                default: begin
                    bus.data_out   <= '0;
                    bus.data_valid <= 1'b0;
                    bus.sync_flag  <= 1'b0;
                end
            endcase

            cnt_r <= (state_r == ST_RUN) ? (cnt_r + CNT_ONE) : '0;

            // stop overrides every other transition, including a same-cycle start
            if (bus.stop) begin
                state_r <= ST_IDLE;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (bus.start) begin
                            state_r        <= ST_WAIT_PHY;
                            mode_r         <= bus.mode;
                            fixed_r        <= bus.fixed_word;
                            bus.word_count <= 32'd0;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_WAIT_PHY: begin
                        train_cnt_r <= '0;
                        state_r     <= bus.phy_ready ? ST_TRAIN : ST_WAIT_PHY;
                    end
                    ST_TRAIN: begin
                        if (!bus.phy_ready) begin
                            state_r <= ST_WAIT_PHY;
                        end else if (train_cnt_r == TRAIN_LAST) begin
                            state_r <= ST_SYNC;
                        end else begin
                            train_cnt_r <= train_cnt_r + TC_W'(1);
                        end
                    end
                    ST_SYNC: begin
                        state_r <= bus.phy_ready ? ST_RUN : ST_WAIT_PHY;
                    end
                    ST_RUN: begin
                        state_r <= bus.phy_ready ? ST_RUN : ST_WAIT_PHY;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tx_pattern_gen.sv
// Self-checking bench for tx_pattern_gen (DATA_W=8, LANES=2, TRAIN_LEN=4):
// a control-vector table for cycle timing, then scoreboarded runs for each payload mode.
module tb_tx_pattern_gen;

    localparam int DW = 8;
    localparam int NL = 2;
    localparam int TL = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    tx_pattern_gen_if #(.DATA_W(DW), .LANES(NL)) bus ();

    tx_pattern_gen #(
        .DATA_W    (DW),
        .LANES     (NL),
        .TRAIN_LEN (TL),
        .SYNC_WORD (32'h0000_00BC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        start;
        logic        stop;
        logic        phy;
        logic [1:0]  mode;
        logic [15:0] exp_data;
        logic        exp_valid;
        logic        exp_sync;
        logic        exp_busy;
        logic [31:0] exp_wc;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        logic        valid;
        logic        sync;
    } exp_t;

    vec_t vecs [16];
    exp_t sb [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] prbs_ref(input logic [6:0] seed, input int n);
        logic       b [0:133];
        logic [7:0] r;
        for (int k = 0; k < 7; k++) b[k] = seed[6-k];
        for (int k = 7; k < 134; k++) b[k] = b[k-7] ^ b[k-6];
        for (int j = 0; j < 8; j++) r[7-j] = b[7 + ((8*n + j) % 127)];
        return r;
    endfunction

    function automatic logic [15:0] exp_payload(input logic [1:0] md, input logic [7:0] fw, input int n);
        case (md)
            2'd0:    return {8'(n + 1), 8'(n)};
            2'd1:    return {prbs_ref(7'h7E, n), prbs_ref(7'h7F, n)};
            default: return {fw, fw};
        endcase
    endfunction

    task automatic push_phase(input logic [1:0] md, input logic [7:0] fw, input int cnt);
        for (int k = 0; k < TL; k++) sb.push_back('{16'hAAAA, 1'b0, 1'b0});
        sb.push_back('{16'hBCBC, 1'b0, 1'b1});
        for (int n = 0; n < cnt; n++) sb.push_back('{exp_payload(md, fw, n), 1'b1, 1'b0});
    endtask

    // Full start..stop run; optional 3-cycle phy_ready drop after phase a and fixed_word change mid-run
    task automatic run_seq(input logic [1:0] md, input logic [7:0] fw, input int a,
                           input bit drop, input int b, input bit chg_fw);
        exp_t e;
        int   pops = 0;
        int   p1 = TL + 1 + a;
        int   total;
        int   lo_cnt = 0;
        int   drop_state = 0;
        bit   stop_sent = 1'b0;
        bit   done = 1'b0;
        sb.delete();
        push_phase(md, fw, a);
        if (drop) push_phase(md, fw, b);
        total = sb.size();
        @(negedge clk);
        bus.mode = md; bus.fixed_word = fw; bus.phy_ready = 1'b1; bus.start = 1'b1; bus.stop = 1'b0;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.stop  = 1'b0;
            if (bus.data_out != 16'h0000 || bus.data_valid || bus.sync_flag) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_out", {bus.data_valid, bus.sync_flag, bus.data_out}, 64'h0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_data", bus.data_out, e.data);
                    chk("sb_valid", bus.data_valid, e.valid);
                    chk("sb_sync", bus.sync_flag, e.sync);
                    pops++;
                end
            end
            if (drop && drop_state == 0 && pops == p1 - 1) begin
                bus.phy_ready = 1'b0;
                drop_state    = 1;
            end else if (drop_state == 1) begin
                lo_cnt++;
                if (lo_cnt == 2) begin
                    chk("drop_valid_low", bus.data_valid, 1'b0);
                    chk("drop_wc_held", bus.word_count, a);
                end
                if (lo_cnt == 3) begin
                    bus.phy_ready = 1'b1;
                    drop_state    = 2;
                end
            end
            if (chg_fw && pops == 10) bus.fixed_word = ~fw;
            if (!stop_sent && pops == total - 1) begin
                bus.stop  = 1'b1;
                stop_sent = 1'b1;
            end
            if (stop_sent && sb.size() == 0) done = 1'b1;
        end
        chk("seq_complete", done, 1'b1);
        @(negedge clk);
        chk("end_data_zero", bus.data_out, 16'h0000);
        chk("end_busy", bus.busy, 1'b0);
        chk("end_wc", bus.word_count, drop ? (a + b) : a);
    endtask

    initial begin
        //        start  stop   phy    mode  data      valid  sync   busy   wc
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 32'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 32'd0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 32'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 32'd0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 32'd0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 2'd0, 16'hAAAA, 1'b0, 1'b0, 1'b1, 32'd0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 2'd0, 16'hAAAA, 1'b0, 1'b0, 1'b1, 32'd0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 2'd0, 16'hAAAA, 1'b0, 1'b0, 1'b1, 32'd0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 2'd0, 16'hAAAA, 1'b0, 1'b0, 1'b1, 32'd0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 2'd0, 16'hBCBC, 1'b0, 1'b1, 1'b1, 32'd0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 2'd0, 16'h0100, 1'b1, 1'b0, 1'b1, 32'd1};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 2'd1, 16'h0201, 1'b1, 1'b0, 1'b1, 32'd2};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 2'd1, 16'h0302, 1'b1, 1'b0, 1'b1, 32'd3};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 32'd3};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 32'd3};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 32'd3};

        rst_n = 1'b0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.mode = 2'd0; bus.fixed_word = 8'h00; bus.phy_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("idle_outputs", {bus.busy, bus.data_valid, bus.sync_flag, bus.data_out, bus.word_count}, 64'h0);
        end

        @(posedge clk);
        #1;
        for (int r = 0; r < 16; r++) begin
            bus.start = vecs[r].start; bus.stop = vecs[r].stop;
            bus.phy_ready = vecs[r].phy; bus.mode = vecs[r].mode;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_data", r), bus.data_out, vecs[r].exp_data);
            chk($sformatf("vec%0d_valid", r), bus.data_valid, vecs[r].exp_valid);
            chk($sformatf("vec%0d_sync", r), bus.sync_flag, vecs[r].exp_sync);
            chk($sformatf("vec%0d_busy", r), bus.busy, vecs[r].exp_busy);
            chk($sformatf("vec%0d_wc", r), bus.word_count, vecs[r].exp_wc);
        end
        bus.start = 1'b0; bus.stop = 1'b0;

        run_seq(2'd0, 8'h00, 300, 1'b0, 0, 1'b0);
        run_seq(2'd1, 8'h00, 300, 1'b0, 0, 1'b0);
        run_seq(2'd2, 8'h5A, 40, 1'b0, 0, 1'b1);
        run_seq(2'd3, 8'h3C, 10, 1'b0, 0, 1'b0);
        run_seq(2'd0, 8'h00, 20, 1'b1, 12, 1'b0);

        // asynchronous reset in the middle of training
        @(negedge clk);
        bus.mode = 2'd0; bus.phy_ready = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 0; c < 20 && bus.data_out != 16'hAAAA; c++) @(negedge clk);
        chk("rst_reached_train", bus.data_out, 16'hAAAA);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_data", bus.data_out, 16'h0000);
        chk("rst_async_busy", bus.busy, 1'b0);
        chk("rst_async_flags", {bus.data_valid, bus.sync_flag}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_idle", {bus.busy, bus.data_out}, 17'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
